icache_ro_dm: RTL and testbench

- Read-only, direct-mapped instruction cache.
- Responds to the instruction fetch stage's I-cache read port: word address plus read enable in; raw instruction word plus stall out.
- On a miss it stalls the fetch stage, fetches a 4-word line from instruction memory over a ready-based handshake, then serves the hit.
- Returns memory words unmodified; the fetch stage does its own byte-order swap.

---
 rtl/icache_ro_dm_if.sv | 38 +++
 rtl/icache_ro_dm.sv | 136 +++++++++++++
 tb/tb_icache_ro_dm.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/icache_ro_dm_if.sv
// icache_ro_dm_if: fetch-side read port and instruction-memory line port of
// the read-only instruction cache, bundled in one interface.
// The cache uses the "slave" modport; the fetch stage and memory model
// together use the "master" modport.
interface icache_ro_dm_if;
    // Fetch stage read port
    logic        p_read;
    logic [29:0] p_addr;
    logic [31:0] p_rdata;
    logic        p_stall;
    // Instruction memory line port
    logic        mem_read;
    logic [27:0] mem_addr;
    logic [127:0] mem_rdata;
    logic        mem_ready;

    modport slave (
        input  p_read,
        input  p_addr,
        output p_rdata,
        output p_stall,
        output mem_read,
        output mem_addr,
        input  mem_rdata,
        input  mem_ready
    );

    modport master (
        output p_read,
        output p_addr,
        input  p_rdata,
        input  p_stall,
        input  mem_read,
        input  mem_addr,
        output mem_rdata,
        output mem_ready
    );
endinterface

// File: rtl/icache_ro_dm.sv
// icache_ro_dm: read-only, direct-mapped instruction cache with 4-word lines.
// Hits are served combinationally in the same cycle. A miss stalls fetch,
// requests the whole line from instruction memory and serves the hit in
// the cycle after the line arrives.
// Optional feature macro: ICACHE_CRITICAL_WORD_EN -- forwards the requested
// word straight from mem_rdata in the mem_ready cycle, saving one stall cycle.
module icache_ro_dm #(
    parameter int SETS = 8
) (
    input  logic              clk,
    input  logic              rst,
    icache_ro_dm_if.slave     bus
);
    localparam int INDEX_W = $clog2(SETS);
    localparam int TAG_W   = 30 - 2 - INDEX_W;

    typedef enum logic {
        IDLE  = 1'b0,
        FETCH = 1'b1
    } state_t;

    // State
    state_t              state_q, state_d;
    logic [27:0]         miss_q, miss_d;     // {tag, index} of the outstanding miss
    logic [SETS-1:0]     valid_q, valid_d;

    // Storage without reset: only meaningful where the valid bit is set
    logic [TAG_W-1:0]    tag_mem  [SETS];
    logic [127:0]        data_mem [SETS];

    // Request decode
    logic [TAG_W-1:0]    req_tag;
    logic [INDEX_W-1:0]  req_index;
    logic [1:0]          req_off;
    logic [127:0]        line_data;
    logic [31:0]         line_word [4];
    logic                hit;

    // Refill target, taken from the latched miss address
    logic                fill_en;
    logic [INDEX_W-1:0]  fill_index;
    logic [TAG_W-1:0]    fill_tag;

    // Combinational outputs
    logic [31:0]         p_rdata_c;
    logic                p_stall_c;
    logic                mem_read_c;

    assign req_tag    = bus.p_addr[29 -: TAG_W];
    assign req_index  = bus.p_addr[2 +: INDEX_W];
    assign req_off    = bus.p_addr[1:0];
    assign line_data  = data_mem[req_index];
    assign hit        = bus.p_read & valid_q[req_index] & (tag_mem[req_index] == req_tag);

    assign fill_index = miss_q[INDEX_W-1:0];
    assign fill_tag   = miss_q[27 -: TAG_W];
    assign fill_en    = (state_q == FETCH) & bus.mem_ready & ~rst;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_line_word
            assign line_word[gi] = line_data[32*gi +: 32];
        end
    endgenerate

`ifdef ICACHE_CRITICAL_WORD_EN
    logic [31:0] mem_word [4];
    generate
        for (gi = 0; gi < 4; gi++) begin : g_mem_word
            assign mem_word[gi] = bus.mem_rdata[32*gi +: 32];
        end
    endgenerate
`endif

    // Next-state and output logic of the miss FSM
    always_comb begin
        state_d    = state_q;
        miss_d     = miss_q;
        valid_d    = valid_q;
        p_stall_c  = 1'b0;
        mem_read_c = 1'b0;
        // Gating with hit keeps p_rdata at zero out of reset and on misses.
        p_rdata_c  = hit ? line_word[req_off] : 32'h0;
        case (state_q)
            IDLE: begin
                if (bus.p_read && !hit) begin
                    p_stall_c = 1'b1;
                    miss_d    = bus.p_addr[29:2];
                    state_d   = FETCH;
                end
            end
            FETCH: begin
                p_stall_c  = 1'b1;
                mem_read_c = 1'b1;
                if (bus.mem_ready) begin
                    valid_d[fill_index] = 1'b1;
                    state_d             = IDLE;
`ifdef ICACHE_CRITICAL_WORD_EN
                    // Forward only if fetch is still asking for the missed line.
                    if (bus.p_addr[29:2] == miss_q) begin
                        p_stall_c = 1'b0;
                        p_rdata_c = mem_word[req_off];
                    end
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM, miss address and valid bits; reset abandons any refill in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            miss_q  <= '0;
            valid_q <= '0;
        end else begin
            state_q <= state_d;
            miss_q  <= miss_d;
            valid_q <= valid_d;
        end
    end

    // Line and tag write on refill completion
    always_ff @(posedge clk) begin
        if (fill_en) begin
            tag_mem[fill_index]  <= fill_tag;
            data_mem[fill_index] <= bus.mem_rdata;
        end
    end

    assign bus.p_rdata  = p_rdata_c;
    assign bus.p_stall  = p_stall_c;
    assign bus.mem_read = mem_read_c;
    assign bus.mem_addr = miss_q;
endmodule

// File: tb/tb_icache_ro_dm.sv
// tb_icache_ro_dm: directed self-checking bench for icache_ro_dm.
// Works in both builds; expectations adapt when ICACHE_CRITICAL_WORD_EN is set.
module tb_icache_ro_dm;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;

`ifdef ICACHE_CRITICAL_WORD_EN
    localparam int CW = 1;
`else
    localparam int CW = 0;
`endif

    localparam logic [127:0] LINE0 = {32'h0000_0033, 32'h0000_0022, 32'h0000_0011, 32'h0000_0000};
    localparam logic [127:0] LINEB = {32'hB333_0003, 32'hB222_0002, 32'hB111_0001, 32'hB000_0000};
    localparam logic [127:0] LINEC = {32'hC333_0003, 32'hC222_0002, 32'hC111_0001, 32'hC000_0000};
    localparam logic [127:0] LINED = {32'hD333_0003, 32'hD222_0002, 32'hD111_0001, 32'hD000_0000};

    icache_ro_dm_if bus_if ();

    icache_ro_dm #(.SETS(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    always #5 clk = ~clk;

    // Advance to just after the next rising edge; mem_ready is a one-cycle pulse.
    task automatic tick();
        @(posedge clk);
        #1;
        bus_if.mem_ready = 1'b0;
    endtask

    // Drive a request and act as memory until the stall drops. Returns what was
    // observed; callers do the comparisons.
    task automatic serve_miss(input logic [29:0] addr, input logic [127:0] line,
                              input int latency, output int stalls,
                              output logic [27:0] maddr, output logic [31:0] rdata,
                              output bit timed_out);
        int fetch;
        stalls    = 0;
        fetch     = 0;
        maddr     = '0;
        rdata     = '0;
        timed_out = 1'b1;
        bus_if.p_read = 1'b1;
        bus_if.p_addr = addr;
        #1;
        for (int cyc = 0; cyc < 40; cyc++) begin
            if (bus_if.mem_read) begin
                fetch++;
                maddr = bus_if.mem_addr;
                if (fetch == latency) begin
                    bus_if.mem_ready = 1'b1;
                    bus_if.mem_rdata = line;
                    #1;
                end
            end
            if (!bus_if.p_stall) begin
                rdata     = bus_if.p_rdata;
                timed_out = 1'b0;
                break;
            end
            stalls++;
            tick();
            #1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus_if.p_read = 1'b0;
        bus_if.p_addr = '0;
        bus_if.mem_ready = 1'b0;
        bus_if.mem_rdata = '0;
        tick();
        tick();
        rst = 1'b0;
        #1;
        n_cmp++; if (bus_if.p_stall !== 1'b0) begin n_bad++; $display("FAIL reset_p_stall got %0b want 0", bus_if.p_stall); end
        n_cmp++; if (bus_if.mem_read !== 1'b0) begin n_bad++; $display("FAIL reset_mem_read got %0b want 0", bus_if.mem_read); end
        n_cmp++; if (bus_if.mem_addr !== 28'h0) begin n_bad++; $display("FAIL reset_mem_addr got %h want 0", bus_if.mem_addr); end
        n_cmp++; if (bus_if.p_rdata !== 32'h0) begin n_bad++; $display("FAIL reset_p_rdata got %h want 0", bus_if.p_rdata); end
        $display("reset: stall=%0b mem_read=%0b", bus_if.p_stall, bus_if.mem_read);
    endtask

    task automatic test_idle_no_read();
        bus_if.p_read = 1'b0;
        bus_if.p_addr = 30'h0000_0010;
        for (int i = 0; i < 5; i++) begin
            #1;
            n_cmp++; if (bus_if.p_stall !== 1'b0) begin n_bad++; $display("FAIL idle_p_stall cyc %0d got %0b want 0", i, bus_if.p_stall); end
            n_cmp++; if (bus_if.mem_read !== 1'b0) begin n_bad++; $display("FAIL idle_mem_read cyc %0d got %0b want 0", i, bus_if.mem_read); end
            $display("idle cyc %0d: stall=%0b mem_read=%0b", i, bus_if.p_stall, bus_if.mem_read);
            tick();
        end
    endtask

    task automatic test_fill();
        int stalls; logic [27:0] maddr; logic [31:0] rdata; bit to;
        bus_if.p_read = 1'b1;
        bus_if.p_addr = 30'h0;
        #1;
        n_cmp++; if (bus_if.p_stall !== 1'b1) begin n_bad++; $display("FAIL fill_first_stall got %0b want 1", bus_if.p_stall); end
        n_cmp++; if (bus_if.mem_read !== 1'b0) begin n_bad++; $display("FAIL fill_detect_mem_read got %0b want 0", bus_if.mem_read); end
        serve_miss(30'h0, LINE0, 3, stalls, maddr, rdata, to);
        n_cmp++; if (to !== 1'b0) begin n_bad++; $display("FAIL fill_timeout got %0b want 0", to); end
        n_cmp++; if (stalls != 4 - CW) begin n_bad++; $display("FAIL fill_stall_cycles got %0d want %0d", stalls, 4 - CW); end
        n_cmp++; if (maddr !== 28'h0) begin n_bad++; $display("FAIL fill_mem_addr got %h want 0", maddr); end
        n_cmp++; if (rdata !== 32'h0) begin n_bad++; $display("FAIL fill_rdata got %h want 0", rdata); end
        $display("fill 0x0: stalls=%0d mem_addr=%h rdata=%h", stalls, maddr, rdata);
        tick();
        #1;
        n_cmp++; if (bus_if.mem_read !== 1'b0) begin n_bad++; $display("FAIL fill_mem_read_drop got %0b want 0", bus_if.mem_read); end
    endtask

    task automatic test_hits();
        logic [31:0] exp_w [4];
        exp_w[0] = 32'h00; exp_w[1] = 32'h11; exp_w[2] = 32'h22; exp_w[3] = 32'h33;
        for (int a = 1; a <= 4; a++) begin
            bus_if.p_read = 1'b1;
            bus_if.p_addr = 30'(a % 4);
            #1;
            n_cmp++; if (bus_if.p_stall !== 1'b0) begin n_bad++; $display("FAIL hit_stall addr %0d got %0b want 0", a % 4, bus_if.p_stall); end
            n_cmp++; if (bus_if.p_rdata !== exp_w[a % 4]) begin n_bad++; $display("FAIL hit_rdata addr %0d got %h want %h", a % 4, bus_if.p_rdata, exp_w[a % 4]); end
            $display("hit addr %0d: stall=%0b rdata=%h", a % 4, bus_if.p_stall, bus_if.p_rdata);
            tick();
        end
    endtask

    task automatic test_mem_ready_idle();
        bus_if.p_read = 1'b0;
        bus_if.mem_ready = 1'b1;
        bus_if.mem_rdata = {4{32'hDEAD_BEEF}};
        tick();
        bus_if.p_read = 1'b1;
        bus_if.p_addr = 30'h1;
        #1;
        n_cmp++; if (bus_if.p_stall !== 1'b0) begin n_bad++; $display("FAIL stray_ready_stall got %0b want 0", bus_if.p_stall); end
        n_cmp++; if (bus_if.p_rdata !== 32'h11) begin n_bad++; $display("FAIL stray_ready_rdata got %h want 00000011", bus_if.p_rdata); end
        $display("stray mem_ready: rdata=%h", bus_if.p_rdata);
        tick();
    endtask

    task automatic test_conflict();
        int stalls; logic [27:0] maddr; logic [31:0] rdata; bit to;
        serve_miss(30'h20, LINEB, 2, stalls, maddr, rdata, to);
        n_cmp++; if (to !== 1'b0) begin n_bad++; $display("FAIL conf_timeout got %0b want 0", to); end
        n_cmp++; if (stalls != 3 - CW) begin n_bad++; $display("FAIL conf_stall_cycles got %0d want %0d", stalls, 3 - CW); end
        n_cmp++; if (maddr !== 28'h8) begin n_bad++; $display("FAIL conf_mem_addr got %h want 0000008", maddr); end
        n_cmp++; if (rdata !== 32'hB000_0000) begin n_bad++; $display("FAIL conf_rdata got %h want b0000000", rdata); end
        $display("conflict 0x20: stalls=%0d mem_addr=%h rdata=%h", stalls, maddr, rdata);
        tick();
        serve_miss(30'h0, LINE0, 1, stalls, maddr, rdata, to);
        n_cmp++; if (stalls != 2 - CW) begin n_bad++; $display("FAIL conf_back_stall_cycles got %0d want %0d", stalls, 2 - CW); end
        n_cmp++; if (maddr !== 28'h0) begin n_bad++; $display("FAIL conf_back_mem_addr got %h want 0", maddr); end
        n_cmp++; if (rdata !== 32'h0) begin n_bad++; $display("FAIL conf_back_rdata got %h want 0", rdata); end
        $display("refetch 0x0: stalls=%0d mem_addr=%h rdata=%h", stalls, maddr, rdata);
        tick();
    endtask

    task automatic test_rst_fetch();
        int stalls; logic [27:0] maddr; logic [31:0] rdata; bit to;
        bus_if.p_read = 1'b1;
        bus_if.p_addr = 30'h8;
        #1;
        n_cmp++; if (bus_if.p_stall !== 1'b1) begin n_bad++; $display("FAIL rstf_detect_stall got %0b want 1", bus_if.p_stall); end
        tick();
        n_cmp++; if (bus_if.mem_read !== 1'b1) begin n_bad++; $display("FAIL rstf_fetch1_mem_read got %0b want 1", bus_if.mem_read); end
        n_cmp++; if (bus_if.mem_addr !== 28'h2) begin n_bad++; $display("FAIL rstf_mem_addr got %h want 0000002", bus_if.mem_addr); end
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus_if.p_read = 1'b0;
        bus_if.mem_ready = 1'b1;
        bus_if.mem_rdata = LINEC;
        #1;
        n_cmp++; if (bus_if.mem_read !== 1'b0) begin n_bad++; $display("FAIL rstf_mem_read_after_rst got %0b want 0", bus_if.mem_read); end
        n_cmp++; if (bus_if.p_stall !== 1'b0) begin n_bad++; $display("FAIL rstf_stall_after_rst got %0b want 0", bus_if.p_stall); end
        $display("reset in FETCH: mem_read=%0b", bus_if.mem_read);
        tick();
        serve_miss(30'h8, LINEC, 2, stalls, maddr, rdata, to);
        n_cmp++; if (stalls != 3 - CW) begin n_bad++; $display("FAIL rstf_remiss_stalls got %0d want %0d", stalls, 3 - CW); end
        n_cmp++; if (rdata !== 32'hC000_0000) begin n_bad++; $display("FAIL rstf_remiss_rdata got %h want c0000000", rdata); end
        $display("re-access 0x8: stalls=%0d rdata=%h", stalls, rdata);
        tick();
    endtask

    task automatic test_critical_word();
        int stalls; logic [27:0] maddr; logic [31:0] rdata; bit to;
        serve_miss(30'h42, LINED, 2, stalls, maddr, rdata, to);
        n_cmp++; if (stalls != 3 - CW) begin n_bad++; $display("FAIL cw_stall_cycles got %0d want %0d", stalls, 3 - CW); end
        n_cmp++; if (maddr !== 28'h10) begin n_bad++; $display("FAIL cw_mem_addr got %h want 0000010", maddr); end
        n_cmp++; if (rdata !== 32'hD222_0002) begin n_bad++; $display("FAIL cw_rdata got %h want d2220002", rdata); end
        $display("miss 0x42: stalls=%0d rdata=%h", stalls, rdata);
        tick();
        bus_if.p_addr = 30'h43;
        #1;
        n_cmp++; if (bus_if.p_stall !== 1'b0) begin n_bad++; $display("FAIL cw_next_hit_stall got %0b want 0", bus_if.p_stall); end
        n_cmp++; if (bus_if.p_rdata !== 32'hD333_0003) begin n_bad++; $display("FAIL cw_next_hit_rdata got %h want d3330003", bus_if.p_rdata); end
        $display("hit 0x43: stall=%0b rdata=%h", bus_if.p_stall, bus_if.p_rdata);
        tick();
    endtask

    initial begin
        test_reset();
        test_idle_no_read();
        test_fill();
        test_hits();
        test_mem_ready_idle();
        test_conflict();
        test_rst_fetch();
        test_critical_word();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
